// File: rtl/csa_tree_pipe.sv
// Pipelined 3:2 carry-save reduction tree with an elastic valid/ready handshake on every stage.
// Optional final carry-propagate stage is enabled by defining CSA_TREE_CPA_EN.
module csa_tree_pipe #(
    parameter int DW  = 16,
    parameter int PP  = 5,
    parameter int STG = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [$clog2(PP+1)-1:0]   pp_num_i,
    input  logic [PP-1:0][DW-1:0]     add_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [DW-1:0]             sum_o,
    output logic [DW-1:0]             carry_o,
    output logic [DW-1:0]             result_o
);
    localparam int LEVEL = PP - 2;
    localparam int NREG  = (LEVEL + STG - 1) / STG;
    localparam int PNW   = $clog2(PP + 1);

    // Slot 0 carries the running sum, slot 1 the shifted carry, slots 2.. the operands still to be folded in.
    typedef logic [PP-1:0][DW-1:0] bundle_t;

    function automatic logic [2*DW-1:0] csa3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] c);
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        x = a ^ b ^ c;
        y = (a & b) | ((a ^ b) & c);
        return {x, y[DW-2:0], 1'b0};
    endfunction

    bundle_t            dat_q [NREG];
    bundle_t            dat_d [NREG];
    bundle_t            in_s;
    bundle_t            cur_s;
    logic [2*DW-1:0]    xy_s;
    logic [NREG-1:0]    v_q;
    logic [NREG-1:0]    v_d;
    logic [NREG-1:0]    load_s;
    logic [NREG:0]      rdy_s;
    logic [NREG:0]      vin_s;
    logic [PNW-1:0]     pp_eff_s;
    logic               last_rdy_s;

    // Operand masking, per-stage compressor levels and the backward ready chain.
    always_comb begin
        pp_eff_s = ((pp_num_i < PNW'(3)) || (pp_num_i > PNW'(PP))) ? PNW'(PP) : pp_num_i;
        for (int k = 0; k < PP; k++) begin
            in_s[k] = (PNW'(k) < pp_eff_s) ? add_i[k] : {DW{1'b0}};
        end
        vin_s       = {v_q, valid_i};
        rdy_s[NREG] = last_rdy_s;
        for (int j = NREG - 1; j >= 0; j--) begin
            rdy_s[j] = !v_q[j] || rdy_s[j+1];
        end
        load_s = vin_s[NREG-1:0] & rdy_s[NREG-1:0];
        v_d    = load_s | (v_q & ~rdy_s[NREG:1]);
        cur_s  = in_s;
        xy_s   = {(2*DW){1'b0}};
        for (int j = 0; j < NREG; j++) begin
            if (j == 0) begin
                cur_s = in_s;
            end else begin
                cur_s = dat_q[(j > 0) ? j - 1 : 0];
            end
            for (int l = 0; l < LEVEL; l++) begin
                if ((l >= j * STG) && (l < (j + 1) * STG)) begin
                    xy_s       = csa3(cur_s[0], cur_s[1], cur_s[l+2]);
                    cur_s[0]   = xy_s[2*DW-1:DW];
                    cur_s[1]   = xy_s[DW-1:0];
                    cur_s[l+2] = {DW{1'b0}};
                end else begin
                    cur_s[l+2] = cur_s[l+2];
                end
            end
            dat_d[j] = cur_s;
        end
    end

    // Stage valid flags and data registers; data only moves on a load so stalled outputs hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q <= {NREG{1'b0}};
            for (int j = 0; j < NREG; j++) begin
                dat_q[j] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int j = 0; j < NREG; j++) begin
                if (load_s[j]) begin
                    dat_q[j] <= dat_d[j];
                end
            end
        end
    end

    assign ready_o = rdy_s[0];

`ifdef CSA_TREE_CPA_EN
    logic          cpa_v_q;
    logic [DW-1:0] sum_q;
    logic [DW-1:0] carry_q;
    logic [DW-1:0] res_q;

    assign last_rdy_s = !cpa_v_q || ready_i;

    // Resolving stage: holds the redundant pair together with its carry-propagated sum.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cpa_v_q <= 1'b0;
            sum_q   <= {DW{1'b0}};
            carry_q <= {DW{1'b0}};
            res_q   <= {DW{1'b0}};
        end else if (v_q[NREG-1] && last_rdy_s) begin
            cpa_v_q <= 1'b1;
            sum_q   <= dat_q[NREG-1][0];
            carry_q <= dat_q[NREG-1][1];
            res_q   <= dat_q[NREG-1][0] + dat_q[NREG-1][1];
        end else if (ready_i) begin
            cpa_v_q <= 1'b0;
        end
    end

    assign valid_o  = cpa_v_q;
    assign sum_o    = sum_q;
    assign carry_o  = carry_q;
    assign result_o = res_q;
`else
    assign last_rdy_s = ready_i;
    assign valid_o    = v_q[NREG-1];
    assign sum_o      = dat_q[NREG-1][0];
    assign carry_o    = dat_q[NREG-1][1];
    assign result_o   = {DW{1'b0}};
`endif

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Directed self-checking bench for csa_tree_pipe: default build (PP=5) plus a PP=8/STG=2/DW=32 instance.
module tb_csa_tree_pipe;
`ifdef CSA_TREE_CPA_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int CAP = LAT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, valid_i, ready_i, ready_o, valid_o;
    logic [2:0]         pp_num;
    logic [4:0][15:0]   add;
    logic [15:0]        sum_o, carry_o, result_o, sc_a;

    logic               b_rst, b_valid_i, b_ready_i, b_ready_o, b_valid_o;
    logic [3:0]         b_pp;
    logic [7:0][31:0]   b_add;
    logic [31:0]        b_sum, b_carry, b_res, sc_b;

    assign sc_a = sum_o + carry_o;
    assign sc_b = b_sum + b_carry;

    csa_tree_pipe #(.DW(16), .PP(5), .STG(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .pp_num_i(pp_num),
        .add_i(add), .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o), .carry_o(carry_o),
        .result_o(result_o)
    );

    csa_tree_pipe #(.DW(32), .PP(8), .STG(2)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .valid_i(b_valid_i), .ready_o(b_ready_o), .pp_num_i(b_pp),
        .add_i(b_add), .valid_o(b_valid_o), .ready_i(b_ready_i), .sum_o(b_sum), .carry_o(b_carry),
        .result_o(b_res)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    int          n_out = 0;
    logic [15:0] q [$];
    logic [15:0] cur_exp;
    logic        last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [4:0][15:0] a, input logic [2:0] n);
        int          e;
        logic [15:0] s;
        e = (n < 3'd3 || n > 3'd5) ? 5 : int'(n);
        s = 16'd0;
        for (int k = 0; k < e; k++) s = s + a[k];
        return s;
    endfunction

    task automatic rand_bundle();
        for (int k = 0; k < 5; k++) add[k] = 16'($urandom);
        pp_num  = 3'($urandom_range(0, 7));
        cur_exp = model(add, pp_num);
    endtask

    // One clock of DUT A: scoreboard at the negedge, then advance to the next negedge.
    task automatic run_cycle();
        logic        acc, tak, hold;
        logic [15:0] hs, hc, hr, e;
        #1;
        acc  = valid_i && ready_o && !rst;
        tak  = valid_o && ready_i && !rst;
        hold = valid_o && !ready_i && !rst;
        hs = sum_o; hc = carry_o; hr = result_o;
        if (!ready_o && !rst) chk("ready_low_not_full", q.size(), CAP);
        if (tak) begin
            if (q.size() == 0) begin
                chk("extra_out", q.size(), 1);
            end else begin
                e = q.pop_front();
                chk("sb_sum_carry", sc_a, e);
`ifdef CSA_TREE_CPA_EN
                chk("sb_result", result_o, e);
`else
                chk("sb_result0", result_o, 16'd0);
`endif
                n_out++;
            end
        end
        if (acc) begin
            q.push_back(cur_exp);
            n_acc++;
        end
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            chk("stall_valid", valid_o, 1'b1);
            chk("stall_sum", sum_o, hs);
            chk("stall_carry", carry_o, hc);
            chk("stall_result", result_o, hr);
        end
        last_acc = acc;
    endtask

    task automatic single(input logic [4:0][15:0] a, input logic [2:0] n, input logic [15:0] e,
                          input string tag);
        int lat;
        add = a; pp_num = n; cur_exp = e; valid_i = 1'b1;
        run_cycle();
        chk({tag, "_accept"}, last_acc, 1'b1);
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 40) begin
            run_cycle();
            lat++;
        end
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_sum"}, sc_a, e);
`ifdef CSA_TREE_CPA_EN
        chk({tag, "_result"}, result_o, e);
`endif
        run_cycle();
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic b_single(input logic [31:0] fill, input logic [31:0] e, input string tag);
        int lat;
        for (int k = 0; k < 8; k++) b_add[k] = (fill == 32'd0) ? 32'(k + 1) : fill;
        b_pp = 4'd8; b_valid_i = 1'b1;
        #1;
        chk({tag, "_ready"}, b_ready_o, 1'b1);
        tick();
        b_valid_i = 1'b0;
        lat = 1;
        while (!b_valid_o && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_sum"}, sc_b, e);
`ifdef CSA_TREE_CPA_EN
        chk({tag, "_result"}, b_res, e);
`endif
        tick();
    endtask

    initial begin
        int first, last, nv, acc0, out0, sent;
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; pp_num = 3'd5; add = '0; cur_exp = 16'd0;
        b_rst = 1'b1; b_valid_i = 1'b0; b_ready_i = 1'b1; b_pp = 4'd8; b_add = '0;
        last_acc = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; b_rst = 1'b0;
        #1;
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_sum", sum_o, 16'd0);
        chk("rst_carry", carry_o, 16'd0);
        chk("rst_result", result_o, 16'd0);
        chk("rst_ready", ready_o, 1'b1);
        chk("b_rst_valid", b_valid_o, 1'b0);

        single({16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 3'd5, 16'd15, "basic");
        single({16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 3'd3, 16'd6, "mask3");
        single({16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 3'd0, 16'd15, "mask0");
        single({16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 3'd7, 16'd15, "mask7");
        single({5{16'hFFFF}}, 3'd5, 16'hFFFB, "wrap");

        // Full throughput: 20 back-to-back bundles.
        first = -1; last = -1; nv = 0; acc0 = n_acc;
        ready_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c < 20) begin
                rand_bundle();
                valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            run_cycle();
            if (valid_o) begin
                if (first < 0) first = c;
                last = c;
                nv++;
            end
        end
        chk("tput_accepts", n_acc - acc0, 20);
        chk("tput_first", first + 1, LAT);
        chk("tput_count", nv, 20);
        chk("tput_contig", last - first, 19);
        chk("tput_drained", q.size(), 0);

        // Backpressure: ready_i follows 1,0,0,1.
        sent = 0; out0 = n_out;
        rand_bundle();
        for (int c = 0; c < 300 && (n_out - out0) < 10; c++) begin
            ready_i = (c % 4 == 0) || (c % 4 == 3);
            valid_i = (sent < 10);
            run_cycle();
            if (last_acc) begin
                sent++;
                rand_bundle();
            end
        end
        ready_i = 1'b1; valid_i = 1'b0;
        chk("bp_outputs", n_out - out0, 10);
        chk("bp_drained", q.size(), 0);

        // Reset with three bundles in flight.
        for (int i = 0; i < 3; i++) begin
            rand_bundle();
            valid_i = 1'b1;
            run_cycle();
        end
        valid_i = 1'b0; rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        q.delete();
        chk("mid_rst_valid", valid_o, 1'b0);
        chk("mid_rst_sum", sum_o, 16'd0);
        chk("mid_rst_carry", carry_o, 16'd0);
        chk("mid_rst_result", result_o, 16'd0);
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            chk("mid_rst_stale", valid_o, 1'b0);
        end
        single({16'h1000, 16'h0200, 16'h0030, 16'h0004, 16'h8000}, 3'd5, 16'h9234, "post_rst");

        // Second configuration: PP=8, STG=2, DW=32.
        b_single(32'd0, 32'd36, "b_basic");
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 8; k++) b_add[k] = $urandom;
            b_valid_i = 1'b1;
            tick();
        end
        b_valid_i = 1'b0; b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        chk("b_mid_rst_valid", b_valid_o, 1'b0);
        chk("b_mid_rst_sum", b_sum, 32'd0);
        chk("b_mid_rst_carry", b_carry, 32'd0);
        chk("b_mid_rst_result", b_res, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("b_mid_rst_stale", b_valid_o, 1'b0);
        end
        b_single(32'hFFFF_FFFF, 32'hFFFF_FFF8, "b_wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end
endmodule
